// File: rtl/core_mem_resp.sv
// One core-memory bank on the processor membus: answers read, write and
// read-modify-write cycles, enforcing a minimum core cycle between accepts.
module core_mem_resp #(
  parameter logic [3:0] SEL       = 4'o0,
  parameter int         ADDR_BITS = 12,
  parameter int         ACK_DLY   = 4,
  parameter int         RD_DLY    = 8,
  parameter int         RD_HOLD   = 4,
  parameter int         CYC_LEN   = 50
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         membus_rq_cyc,
  input  logic         membus_rd_rq,
  input  logic         membus_wr_rq,
  input  logic [21:35] membus_ma,
  input  logic [18:21] membus_sel,
  input  logic         membus_fmc_select,
  input  logic         membus_wr_rs,
  input  logic [0:35]  membus_mb_in,
  output logic         membus_addr_ack,
  output logic         membus_rd_rs,
  output logic [0:35]  membus_mb_out
);
  localparam int CW = 16;
  // Event times are compared against the next counter value so that an
  // output registered on that edge is visible while the counter equals it.
  localparam logic [CW-1:0] C_ACK    = CW'(ACK_DLY);
  localparam logic [CW-1:0] C_RD     = CW'(RD_DLY);
  localparam logic [CW-1:0] C_RD_END = CW'(RD_DLY + RD_HOLD);
  localparam logic [CW-1:0] C_CYC    = CW'(CYC_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_ACK, S_READ, S_WR_WAIT, S_RESTORE} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_rd;
  logic                 r_wr;
  logic                 r_armed;
  logic                 r_ack;
  logic                 r_rd_rs;
  logic [35:0]          r_mb_out;
  logic [35:0]          r_mem [0:(1<<ADDR_BITS)-1];

  logic [CW-1:0]        w_cnt_nxt;
  logic                 w_accept;
  logic                 w_we;
  logic                 w_unused_ma;

  assign w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
  assign w_accept  = membus_rq_cyc & (membus_rd_rq | membus_wr_rq) &
                     (membus_sel == SEL) & ~membus_fmc_select & r_armed;
  assign w_we      = (r_state == S_WR_WAIT) & membus_wr_rs;
  assign w_unused_ma = ^membus_ma[21:35-ADDR_BITS];

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_addr] <= membus_mb_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_armed  <= 1'b0;
      r_ack    <= 1'b0;
      r_rd_rs  <= 1'b0;
      r_mb_out <= '0;
    end else begin
      if (!membus_rq_cyc) r_armed <= 1'b1;
      r_cnt <= w_cnt_nxt;
      if (r_ack && !membus_rq_cyc) r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= membus_ma[36-ADDR_BITS:35];
            r_rd    <= membus_rd_rq;
            r_wr    <= membus_wr_rq;
            r_armed <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          if (!membus_rq_cyc) begin
            r_state <= S_RESTORE;
          end else if (w_cnt_nxt == C_ACK) begin
            r_ack   <= 1'b1;
            r_state <= r_rd ? S_READ : S_WR_WAIT;
          end
        end
        S_READ: begin
          if (w_cnt_nxt == C_RD) begin
            r_rd_rs  <= 1'b1;
            r_mb_out <= r_mem[r_addr];
          end else if (w_cnt_nxt == C_RD_END) begin
            r_rd_rs  <= 1'b0;
            r_mb_out <= '0;
            r_state  <= r_wr ? S_WR_WAIT : S_RESTORE;
          end
        end
        S_WR_WAIT: begin
          if (membus_wr_rs) r_state <= S_RESTORE;
        end
        S_RESTORE: begin
          if (w_cnt_nxt >= C_CYC) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign membus_addr_ack = r_ack;
  assign membus_rd_rs    = r_rd_rs;
  assign membus_mb_out   = r_mb_out;
endmodule
